// File: rtl/powlib_buscross_wrr_if.sv
// Bus bundle for the weighted round-robin crossbar: packed writer-side
// request/ready signals, packed reader-side registered outputs and the
// saturating miss counter.
interface powlib_buscross_wrr_if #(
  parameter int B_WRS = 3,
  parameter int B_RDS = 3,
  parameter int B_AW  = 16,
  parameter int B_DW  = 32,
  parameter int B_SW  = 2,
  parameter int B_CW  = 8
);
  logic [B_WRS*B_DW-1:0] wrdatas;
  logic [B_WRS*B_AW-1:0] wraddrs;
  logic [B_WRS-1:0]      wrlasts;
  logic [B_WRS-1:0]      wrvlds;
  logic [B_WRS-1:0]      wrrdys;
  logic [B_RDS*B_DW-1:0] rddatas;
  logic [B_RDS*B_AW-1:0] rdaddrs;
  logic [B_RDS-1:0]      rdlasts;
  logic [B_RDS*B_SW-1:0] rdsrcs;
  logic [B_RDS-1:0]      rdvlds;
  logic [B_RDS-1:0]      rdrdys;
  logic [B_CW-1:0]       missed;

  modport master (
    output wrdatas, wraddrs, wrlasts, wrvlds, rdrdys,
    input  wrrdys, rddatas, rdaddrs, rdlasts, rdsrcs, rdvlds, missed
  );

  modport slave (
    input  wrdatas, wraddrs, wrlasts, wrvlds, rdrdys,
    output wrrdys, rddatas, rdaddrs, rdlasts, rdsrcs, rdvlds, missed
  );
endinterface

// File: rtl/powlib_buscross_wrr.sv
// Single-clock crossbar: address-decoded routing from writers to readers,
// one packet-locked weighted round-robin arbiter per reader, one output
// register per reader, and a saturating counter of beats hitting no window.
module powlib_buscross_wrr #(
  parameter int B_WRS = 3,
  parameter int B_RDS = 3,
  parameter int B_AW  = 16,
  parameter int B_DW  = 32,
  parameter int B_SW  = 2,
  parameter int B_CW  = 8,
  parameter logic [B_RDS*B_AW-1:0] B_BASES   = {16'h4000, 16'h2000, 16'h0000},
  parameter logic [B_RDS*B_AW-1:0] B_SIZES   = {16'h1FFF, 16'h1FFF, 16'h1FFF},
  parameter logic [B_WRS*4-1:0]    B_WEIGHTS = {4'd1, 4'd1, 4'd2}
) (
  input logic                  clk,
  input logic                  rst,
  powlib_buscross_wrr_if.slave bus
);
  localparam int RW = (B_RDS > 1) ? $clog2(B_RDS) : 1;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  arb_state_t      st_q   [B_RDS];
  arb_state_t      st_d   [B_RDS];
  logic [B_SW-1:0] win_q  [B_RDS];
  logic [B_SW-1:0] win_d  [B_RDS];
  logic [B_SW-1:0] ptr_q  [B_RDS];
  logic [B_SW-1:0] ptr_d  [B_RDS];
  logic [3:0]      cred_q [B_RDS];
  logic [3:0]      cred_d [B_RDS];
  logic [B_SW-1:0] gsel   [B_RDS];
  logic [RW-1:0]   tgt    [B_WRS];
  logic [B_RDS-1:0] mid_q, mid_d, gval, xfer;
  logic [B_WRS-1:0] hit, lock, miss, rdy;

  logic [B_RDS*B_DW-1:0] rd_data_p1;
  logic [B_RDS*B_AW-1:0] rd_addr_p1;
  logic [B_RDS*B_SW-1:0] rd_src_p1;
  logic [B_RDS-1:0]      rd_last_p1, vld_p1;
  logic [B_CW-1:0]       miss_cnt, miss_cnt_d;

  // Window test in B_AW+1 bits so base+size past the top does not wrap.
  function automatic logic in_win(input logic [B_AW-1:0] a, input int j);
    logic [B_AW:0] lo, hi, ax;
    lo = {1'b0, B_BASES[j*B_AW +: B_AW]};
    hi = lo + {1'b0, B_SIZES[j*B_AW +: B_AW]};
    ax = {1'b0, a};
    return (ax >= lo) && (ax <= hi);
  endfunction

  function automatic logic [3:0] weight_of(input logic [B_SW-1:0] w);
    logic [3:0] v;
    v = B_WEIGHTS[int'(w)*4 +: 4];
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  function automatic logic [B_SW-1:0] next_ptr(input logic [B_SW-1:0] w);
    int n;
    n = int'(w) + 1;
    if (n >= B_WRS) n = 0;
    return B_SW'(n);
  endfunction

  function automatic logic [B_CW-1:0] sat_add(input logic [B_CW-1:0] a, input int n);
    longint s, lim;
    s   = longint'(a) + longint'(n);
    lim = (longint'(1) << B_CW) - 1;
    return (s > lim) ? {B_CW{1'b1}} : B_CW'(s);
  endfunction

  // Address decode: lowest matching reader wins; no match is a miss.
  always_comb begin
    for (int i = 0; i < B_WRS; i++) begin
      hit[i] = 1'b0;
      tgt[i] = '0;
      for (int j = B_RDS - 1; j >= 0; j--) begin
        if (in_win(bus.wraddrs[i*B_AW +: B_AW], j)) begin
          hit[i] = 1'b1;
          tgt[i] = RW'(j);
        end
      end
      miss[i] = !rst && bus.wrvlds[i] && !hit[i];
    end
  end

  // A writer held mid-packet by one reader may not be granted by another.
  always_comb begin
    lock = '0;
    for (int j = 0; j < B_RDS; j++)
      for (int i = 0; i < B_WRS; i++)
        if (st_q[j] == GRANT && mid_q[j] && win_q[j] == B_SW'(i)) lock[i] = 1'b1;
  end

  // Per-reader grant selection (round-robin scan from ptr) and transfer.
  always_comb begin
    logic [B_WRS-1:0] req;
    logic             found;
    logic [B_SW-1:0]  pick;
    int               idx;
    for (int j = 0; j < B_RDS; j++) begin
      req   = '0;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < B_WRS; i++)
        req[i] = bus.wrvlds[i] && hit[i] && (tgt[i] == RW'(j)) && !lock[i];
      for (int k = 0; k < B_WRS; k++) begin
        idx = (int'(ptr_q[j]) + k) % B_WRS;
        if (!found && req[idx]) begin
          found = 1'b1;
          pick  = B_SW'(idx);
        end
      end
      gsel[j] = (st_q[j] == IDLE) ? pick : win_q[j];
      gval[j] = (st_q[j] == IDLE) ? found : 1'b1;
      xfer[j] = !rst && gval[j] && bus.wrvlds[gsel[j]] && hit[gsel[j]] &&
                (tgt[gsel[j]] == RW'(j)) && (!vld_p1[j] || bus.rdrdys[j]);
    end
  end

  // Writer ready: misses are absorbed at once, routed beats on transfer.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < B_WRS; i++) begin
      if (miss[i]) rdy[i] = 1'b1;
      for (int j = 0; j < B_RDS; j++)
        if (xfer[j] && gsel[j] == B_SW'(i)) rdy[i] = 1'b1;
    end
  end

  // Arbiter next state: credit per packet, release on credit out or idle winner.
  always_comb begin
    for (int j = 0; j < B_RDS; j++) begin
      st_d[j]   = st_q[j];
      win_d[j]  = win_q[j];
      cred_d[j] = cred_q[j];
      ptr_d[j]  = ptr_q[j];
      mid_d[j]  = mid_q[j];
      if (st_q[j] == IDLE) begin
        if (gval[j]) begin
          st_d[j]   = GRANT;
          win_d[j]  = gsel[j];
          cred_d[j] = weight_of(gsel[j]);
          mid_d[j]  = 1'b0;
          if (xfer[j]) begin
            if (bus.wrlasts[gsel[j]]) begin
              if (weight_of(gsel[j]) == 4'd1) begin
                st_d[j]   = IDLE;
                ptr_d[j]  = next_ptr(gsel[j]);
                cred_d[j] = 4'd0;
              end else begin
                cred_d[j] = weight_of(gsel[j]) - 4'd1;
              end
            end else begin
              mid_d[j] = 1'b1;
            end
          end
        end
      end else if (xfer[j]) begin
        if (bus.wrlasts[win_q[j]]) begin
          mid_d[j] = 1'b0;
          if (cred_q[j] <= 4'd1) begin
            st_d[j]   = IDLE;
            ptr_d[j]  = next_ptr(win_q[j]);
            cred_d[j] = 4'd0;
          end else begin
            cred_d[j] = cred_q[j] - 4'd1;
          end
        end else begin
          mid_d[j] = 1'b1;
        end
      end else if (!mid_q[j] && !(bus.wrvlds[win_q[j]] && hit[win_q[j]] &&
                                   tgt[win_q[j]] == RW'(j))) begin
        st_d[j]   = IDLE;
        ptr_d[j]  = next_ptr(win_q[j]);
        cred_d[j] = 4'd0;
        mid_d[j]  = 1'b0;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < B_RDS; j++) begin
        st_q[j]   <= IDLE;
        win_q[j]  <= '0;
        ptr_q[j]  <= '0;
        cred_q[j] <= '0;
      end
      mid_q <= '0;
    end else begin
      for (int j = 0; j < B_RDS; j++) begin
        st_q[j]   <= st_d[j];
        win_q[j]  <= win_d[j];
        ptr_q[j]  <= ptr_d[j];
        cred_q[j] <= cred_d[j];
      end
      mid_q <= mid_d;
    end
  end

  // Stage p1: reader output registers, hold while valid and not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= '0;
      rd_data_p1 <= '0;
      rd_addr_p1 <= '0;
      rd_last_p1 <= '0;
      rd_src_p1  <= '0;
    end else begin
      for (int j = 0; j < B_RDS; j++) begin
        if (xfer[j]) begin
          vld_p1[j]                  <= 1'b1;
          rd_data_p1[j*B_DW +: B_DW] <= bus.wrdatas[int'(gsel[j])*B_DW +: B_DW];
          rd_addr_p1[j*B_AW +: B_AW] <= bus.wraddrs[int'(gsel[j])*B_AW +: B_AW];
          rd_last_p1[j]              <= bus.wrlasts[gsel[j]];
          rd_src_p1[j*B_SW +: B_SW]  <= gsel[j];
        end else if (bus.rdrdys[j]) begin
          vld_p1[j] <= 1'b0;
        end
      end
    end
  end

  // Miss counter: adds the number of missing writers this cycle, saturating.
  always_comb begin
    int nm;
    nm = 0;
    for (int i = 0; i < B_WRS; i++) nm += int'(miss[i]);
    miss_cnt_d = sat_add(miss_cnt, nm);
  end

  // Miss counter register.
  always_ff @(posedge clk) begin
    if (rst) miss_cnt <= '0;
    else     miss_cnt <= miss_cnt_d;
  end

  assign bus.wrrdys  = rdy;
  assign bus.rddatas = rd_data_p1;
  assign bus.rdaddrs = rd_addr_p1;
  assign bus.rdlasts = rd_last_p1;
  assign bus.rdsrcs  = rd_src_p1;
  assign bus.rdvlds  = vld_p1;
  assign bus.missed  = miss_cnt;
endmodule

// File: tb/tb_powlib_buscross_wrr.sv
// Scoreboard bench for powlib_buscross_wrr: per-writer beat queues drive the
// writers, accepted beats are pushed to per-reader expectation queues using
// the bench's own address map, reader handshakes pop and compare.
module tb_powlib_buscross_wrr;
  localparam int NW = 3, NR = 3, AW = 16, DW = 32, SW = 2, CW = 8;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic l; logic [SW-1:0] s;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  powlib_buscross_wrr_if #(.B_WRS(NW), .B_RDS(NR), .B_AW(AW), .B_DW(DW), .B_SW(SW), .B_CW(CW)) bus ();

  powlib_buscross_wrr #(.B_WRS(NW), .B_RDS(NR), .B_AW(AW), .B_DW(DW), .B_SW(SW), .B_CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  beat_t wq [NW][$];
  exp_t  sbq[NR][$];
  int    srclog[NR][$];
  int    cyclog[NR][$];
  int    popcnt[NR];
  int    errors = 0, checks = 0, cyc = 0, exp_miss = 0;
  logic [NR-1:0] rdy_mask = '1;
  bit    rand_rdy = 0;

  function automatic beat_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.a = a; b.d = d; b.l = l;
    return b;
  endfunction

  // Reference address map: 0x0000-0x1FFF, 0x2000-0x3FFF, 0x4000-0x5FFF.
  function automatic int decode(input logic [AW-1:0] a);
    if (a <= 16'h1FFF) return 0;
    if (a <= 16'h3FFF) return 1;
    if (a <= 16'h5FFF) return 2;
    return -1;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NW; i++) if (wq[i].size() != 0) return 1;
    for (int j = 0; j < NR; j++) if (sbq[j].size() != 0) return 1;
    return 0;
  endfunction

  task automatic drive();
    beat_t b;
    for (int i = 0; i < NW; i++) begin
      if (wq[i].size() != 0) begin
        b = wq[i][0];
        bus.wrvlds[i] = 1'b1;
        bus.wraddrs[i*AW +: AW] = b.a;
        bus.wrdatas[i*DW +: DW] = b.d;
        bus.wrlasts[i] = b.l;
      end else begin
        bus.wrvlds[i] = 1'b0;
        bus.wraddrs[i*AW +: AW] = '0;
        bus.wrdatas[i*DW +: DW] = '0;
        bus.wrlasts[i] = 1'b0;
      end
    end
    if (rand_rdy) rdy_mask = NR'($urandom_range(0, (1 << NR) - 1));
    bus.rdrdys = rdy_mask;
  endtask

  task automatic step();
    logic [NW-1:0] acc;
    exp_t e, g;
    beat_t b;
    int t;
    acc = '0;
    #1;
    if (!rst) begin
      for (int j = 0; j < NR; j++) begin
        if (bus.rdvlds[j] && bus.rdrdys[j]) begin
          g.a = bus.rdaddrs[j*AW +: AW];
          g.d = bus.rddatas[j*DW +: DW];
          g.l = bus.rdlasts[j];
          g.s = bus.rdsrcs[j*SW +: SW];
          checks++;
          if (sbq[j].size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected rd%0d: got a=%h d=%h s=%0d, required no beat", j, g.a, g.d, g.s);
          end else begin
            e = sbq[j].pop_front();
            if (g !== e) begin
              errors++;
              $display("FAIL sb_beat rd%0d: got a=%h d=%h l=%b s=%0d, required a=%h d=%h l=%b s=%0d",
                       j, g.a, g.d, g.l, g.s, e.a, e.d, e.l, e.s);
            end
          end
          srclog[j].push_back(int'(g.s));
          cyclog[j].push_back(cyc);
          popcnt[j]++;
        end
      end
      for (int i = 0; i < NW; i++) begin
        acc[i] = bus.wrvlds[i] && bus.wrrdys[i];
        if (acc[i]) begin
          b = wq[i][0];
          t = decode(b.a);
          if (t < 0) begin
            if (exp_miss < 255) exp_miss++;
          end else begin
            e.a = b.a; e.d = b.d; e.l = b.l; e.s = SW'(i);
            sbq[t].push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < NW; i++) if (acc[i]) b = wq[i].pop_front();
    drive();
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while (busy() && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", maxc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NW; i++) wq[i].delete();
    rand_rdy = 0;
    rdy_mask = '1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < NR; j++) begin
      sbq[j].delete(); srclog[j].delete(); cyclog[j].delete(); popcnt[j] = 0;
    end
    exp_miss = 0;
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wrvlds  = '1;
    bus.wraddrs = {16'h6000, 16'h2000, 16'h0000};
    bus.wrdatas = '1;
    bus.wrlasts = '1;
    bus.rdrdys  = '1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.wrrdys !== 3'b000) begin errors++; $display("FAIL rst_wrrdys: got %b, required 000", bus.wrrdys); end
    checks++; if (bus.rdvlds !== 3'b000) begin errors++; $display("FAIL rst_rdvlds: got %b, required 000", bus.rdvlds); end
    checks++; if (bus.missed !== 8'd0) begin errors++; $display("FAIL rst_missed: got %0d, required 0", bus.missed); end
    checks++;
    if (bus.rddatas !== '0 || bus.rdaddrs !== '0 || bus.rdsrcs !== '0 || bus.rdlasts !== '0) begin
      errors++;
      $display("FAIL rst_regs: got d=%h a=%h s=%h l=%b, required all zero", bus.rddatas, bus.rdaddrs, bus.rdsrcs, bus.rdlasts);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    wq[0].push_back(mk(16'h2010, 32'hDEADBEEF, 1'b1));
    drive();
    step();
    #1;
    checks++; if (bus.rdvlds !== 3'b010) begin errors++; $display("FAIL single_vld: got %b, required 010", bus.rdvlds); end
    checks++; if (bus.rdaddrs[AW +: AW] !== 16'h2010) begin errors++; $display("FAIL single_addr: got %h, required 2010", bus.rdaddrs[AW +: AW]); end
    checks++; if (bus.rddatas[DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h, required deadbeef", bus.rddatas[DW +: DW]); end
    checks++; if (bus.rdsrcs[SW +: SW] !== 2'd0) begin errors++; $display("FAIL single_src: got %0d, required 0", bus.rdsrcs[SW +: SW]); end
    checks++; if (bus.rdlasts[1] !== 1'b1) begin errors++; $display("FAIL single_last: got %b, required 1", bus.rdlasts[1]); end
    run_idle(20);
  endtask

  task automatic test_wrr_order();
    int exp_ord[8] = '{0, 0, 1, 2, 0, 0, 1, 2};
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NW; i++) wq[i].push_back(mk(16'h0000, 32'h100 * (i + 1) + k, 1'b1));
    drive();
    run_idle(100);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (srclog[0].size() <= k) begin
        errors++; $display("FAIL wrr_order[%0d]: got no beat, required src %0d", k, exp_ord[k]);
      end else if (srclog[0][k] != exp_ord[k]) begin
        errors++; $display("FAIL wrr_order[%0d]: got src %0d, required %0d", k, srclog[0][k], exp_ord[k]);
      end
    end
    checks++;
    if (cyclog[0].size() < 8 || cyclog[0][7] - cyclog[0][0] != 7) begin
      errors++; $display("FAIL wrr_throughput: got %0d beats, 8 beats not spread over 8 cycles", cyclog[0].size());
    end
    checks++; if (popcnt[0] != 24) begin errors++; $display("FAIL wrr_count: got %0d, required 24", popcnt[0]); end
  endtask

  task automatic test_packet_lock();
    int exp_src[5] = '{1, 1, 1, 1, 2};
    do_reset();
    for (int k = 0; k < 4; k++) wq[1].push_back(mk(16'h4000 + AW'(k), 32'h31 + k, k == 3));
    drive();
    step();
    wq[2].push_back(mk(16'h4000, 32'h99, 1'b1));
    drive();
    run_idle(40);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (srclog[2].size() <= k) begin
        errors++; $display("FAIL lock_order[%0d]: got no beat, required src %0d", k, exp_src[k]);
      end else if (srclog[2][k] != exp_src[k]) begin
        errors++; $display("FAIL lock_order[%0d]: got src %0d, required %0d", k, srclog[2][k], exp_src[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    do_reset();
    for (int k = 0; k < 10; k++) wq[0].push_back(mk(16'h0040 + AW'(k), 32'hA000 + k, 1'b1));
    drive();
    repeat (3) step();
    rdy_mask = 3'b110;
    drive();
    held = bus.rddatas[DW-1:0];
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      checks++; if (bus.rdvlds[0] !== 1'b1) begin errors++; $display("FAIL bp_vld c%0d: got %b, required 1", c, bus.rdvlds[0]); end
      checks++; if (bus.rddatas[DW-1:0] !== held) begin errors++; $display("FAIL bp_stable c%0d: got %h, required %h", c, bus.rddatas[DW-1:0], held); end
      checks++; if (bus.wrrdys[0] !== 1'b0) begin errors++; $display("FAIL bp_wrrdy c%0d: got %b, required 0", c, bus.wrrdys[0]); end
    end
    rdy_mask = '1;
    drive();
    run_idle(60);
    checks++; if (popcnt[0] != 10) begin errors++; $display("FAIL bp_count: got %0d, required 10", popcnt[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rand_rdy = 1;
    for (int k = 0; k < 6; k++) begin
      wq[0].push_back(mk(16'h0100 + AW'(k), 32'hB000 + k, k[0]));
      wq[1].push_back(mk(16'h2100 + AW'(k), 32'hB100 + k, k[0]));
      wq[2].push_back(mk(16'h4100 + AW'(k), 32'hB200 + k, k[0]));
    end
    drive();
    run_idle(400);
    rand_rdy = 0;
    for (int j = 0; j < NR; j++) begin
      checks++; if (popcnt[j] != 6) begin errors++; $display("FAIL b2b_count rd%0d: got %0d, required 6", j, popcnt[j]); end
    end
  endtask

  task automatic test_decode_edges();
    logic [AW-1:0] addrs[7] = '{16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000, 16'h5FFF, 16'h6000, 16'hFFFF};
    do_reset();
    for (int k = 0; k < 7; k++) wq[0].push_back(mk(addrs[k], 32'hE000 + k, 1'b1));
    drive();
    run_idle(60);
    checks++; if (bus.missed !== 8'd2) begin errors++; $display("FAIL edge_missed: got %0d, required 2", bus.missed); end
    checks++;
    if (popcnt[0] != 1 || popcnt[1] != 2 || popcnt[2] != 2) begin
      errors++; $display("FAIL edge_route: got %0d/%0d/%0d, required 1/2/2", popcnt[0], popcnt[1], popcnt[2]);
    end
  endtask

  task automatic test_miss();
    do_reset();
    wq[0].push_back(mk(16'h6000, 32'h1, 1'b1));
    wq[1].push_back(mk(16'h6000, 32'h2, 1'b1));
    drive();
    #1;
    checks++; if (bus.wrrdys[1:0] !== 2'b11) begin errors++; $display("FAIL miss_rdy: got %b, required 11", bus.wrrdys[1:0]); end
    step();
    #1;
    checks++; if (bus.missed !== 8'd2) begin errors++; $display("FAIL miss_two: got %0d, required 2", bus.missed); end
    checks++; if (bus.rdvlds !== 3'b000) begin errors++; $display("FAIL miss_vld: got %b, required 000", bus.rdvlds); end
    for (int k = 0; k < 300; k++) wq[0].push_back(mk(16'h8000 + AW'(k), 32'h0, 1'b1));
    drive();
    run_idle(400);
    checks++; if (bus.missed !== 8'd255) begin errors++; $display("FAIL miss_sat: got %0d, required 255", bus.missed); end
    checks++; if (int'(bus.missed) != exp_miss) begin errors++; $display("FAIL miss_model: got %0d, required %0d", bus.missed, exp_miss); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) wq[1].push_back(mk(16'h0010 + AW'(k), 32'hC100 + k, k == 3));
    drive();
    repeat (2) step();
    rst = 1'b1;
    drive();
    #1;
    checks++; if (bus.wrrdys !== 3'b000) begin errors++; $display("FAIL rstmid_wrrdys: got %b, required 000", bus.wrrdys); end
    step();
    rst = 1'b0;
    for (int i = 0; i < NW; i++) wq[i].delete();
    for (int j = 0; j < NR; j++) begin
      sbq[j].delete(); srclog[j].delete(); popcnt[j] = 0;
    end
    drive();
    #1;
    checks++;
    if (bus.rdvlds !== 3'b000 || bus.rddatas !== '0 || bus.rdsrcs !== '0 || bus.missed !== 8'd0) begin
      errors++; $display("FAIL rstmid_outputs: got v=%b d=%h s=%h m=%0d, required all zero", bus.rdvlds, bus.rddatas, bus.rdsrcs, bus.missed);
    end
    wq[2].push_back(mk(16'h0000, 32'hC0DE, 1'b1));
    drive();
    run_idle(20);
    checks++;
    if (srclog[0].size() != 1 || srclog[0][0] != 2) begin
      errors++; $display("FAIL rstmid_grant: got %0d beats, required one beat from src 2", srclog[0].size());
    end
  endtask

  initial begin
    bus.wrvlds  = '0;
    bus.wraddrs = '0;
    bus.wrdatas = '0;
    bus.wrlasts = '0;
    bus.rdrdys  = '1;
    test_reset();
    test_single();
    test_wrr_order();
    test_packet_lock();
    test_backpressure();
    test_back_to_back();
    test_decode_edges();
    test_miss();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
